// File: rtl/ft245_pkg.sv
// Shared constants for the FT245 synchronous FIFO device model.
package ft245_pkg;

    localparam int FT245_DATA_W = 8;

    localparam int ERR_RD_NO_OE = 0;
    localparam int ERR_RD_WR    = 1;
    localparam int ERR_WR_OE    = 2;

    typedef logic [FT245_DATA_W-1:0] ft245_byte_t;

endpackage

// File: rtl/ft245_byte_fifo.sv
// Circular byte FIFO with pop-before-push: a full FIFO accepts a push when it is popped in the same cycle.
module ft245_byte_fifo
    import ft245_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic [7:0]          din_i,
    output logic [7:0]          head_o,
    output logic [DEPTH_LOG2:0] count_o,
    output logic                full_o,
    output logic                empty_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    ft245_byte_t             mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q;
    logic [DEPTH_LOG2:0]     count_q;
    logic [DEPTH_LOG2:0]     count_d;
    logic                    do_push;
    logic                    do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Storage is left unreset; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/ft245_device_model.sv
// FTDI-side model of the FT245 synchronous FIFO: strobe decode, registered flags, data bus drive and sticky protocol errors.
module ft245_device_model
    import ft245_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    _rd,
    input  logic                    _wr,
    input  logic                    _oe,
    output logic                    _rxf,
    output logic                    _txe,
    inout  wire  [FT245_DATA_W-1:0] data,
    input  logic [FT245_DATA_W-1:0] pc_tx_data,
    input  logic                    pc_tx_valid,
    output logic                    pc_tx_ready,
    output logic [FT245_DATA_W-1:0] pc_rx_data,
    output logic                    pc_rx_valid,
    input  logic                    pc_rx_ready,
    output logic [2:0]              err
);

    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    ft245_byte_t         rx_head;
    ft245_byte_t         tx_head;
    logic [DEPTH_LOG2:0] rx_count;
    logic [DEPTH_LOG2:0] tx_count;
    logic [DEPTH_LOG2:0] rx_count_d;
    logic [DEPTH_LOG2:0] tx_count_d;
    logic                rx_full;
    logic                rx_empty;
    logic                tx_full;
    logic                tx_empty;
    logic                rx_push;
    logic                rx_pop;
    logic                tx_push;
    logic                tx_pop;
    logic                oe_prev_q;
    logic [2:0]          err_q;
    logic [2:0]          err_d;

    // PC streams use plain valid/ready: a byte moves on a rising edge where
    // valid and ready are both high; valid never depends on ready.
    assign pc_tx_ready = !reset && !rx_full;
    assign pc_rx_valid = !reset && !tx_empty;
    assign pc_rx_data  = tx_head;

    assign rx_push = pc_tx_valid && pc_tx_ready;
    assign rx_pop  = !reset && !_rd && !_rxf && !rx_empty;
    assign tx_push = !reset && !_wr && !_txe && !tx_full;
    assign tx_pop  = pc_rx_valid && pc_rx_ready;

    assign rx_count_d = rx_count + CW'(rx_push) - CW'(rx_pop);
    assign tx_count_d = tx_count + CW'(tx_push) - CW'(tx_pop);

    assign data = !_oe ? rx_head : {FT245_DATA_W{1'bz}};
    assign err  = err_q;

    ft245_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rxq (
        .clk     (clk),
        .reset   (reset),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .din_i   (pc_tx_data),
        .head_o  (rx_head),
        .count_o (rx_count),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    ft245_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_txq (
        .clk     (clk),
        .reset   (reset),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .din_i   (data),
        .head_o  (tx_head),
        .count_o (tx_count),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    always_comb begin
        err_d = '0;
        err_d[ERR_RD_NO_OE] = !_rd && oe_prev_q;
        err_d[ERR_RD_WR]    = !_rd && !_wr;
        err_d[ERR_WR_OE]    = !_wr && !_oe;
    end

    // Flags look at the post-edge counts so the last pop raises _rxf immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            _rxf  <= 1'b1;
            _txe  <= 1'b1;
            err_q <= '0;
        end else begin
            _rxf  <= (rx_count_d == '0);
            _txe  <= (tx_count_d == FULL_CNT);
            err_q <= err_q | err_d;
        end
    end

    always_ff @(posedge clk) begin
        oe_prev_q <= _oe;
    end

endmodule

// File: tb/tb_ft245_device_model.sv
// Randomized and directed bench for the FT245 device model against a queue-based reference.
module tb_ft245_device_model;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rd_n, wr_n, oe_n;
    logic       rxf_n, txe_n;
    wire  [7:0] data;
    logic [7:0] drv_val;
    logic [7:0] pc_tx_data;
    logic       pc_tx_valid, pc_tx_ready;
    logic [7:0] pc_rx_data;
    logic       pc_rx_valid, pc_rx_ready;
    logic [2:0] err;

    // Reference state: byte queues for each direction plus flag/error shadows.
    logic [7:0] rx_exp_q[$];
    logic [7:0] tx_exp_q[$];
    logic       rxf_m, txe_m, oe_prev_m;
    logic [2:0] err_m;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // The master drives the bus whenever it is not asking the device to drive.
    assign data = oe_n ? drv_val : 8'hzz;

    ft245_device_model #(.DEPTH_LOG2(4)) dut (
        .clk         (clk),
        .reset       (reset),
        ._rd         (rd_n),
        ._wr         (wr_n),
        ._oe         (oe_n),
        ._rxf        (rxf_n),
        ._txe        (txe_n),
        .data        (data),
        .pc_tx_data  (pc_tx_data),
        .pc_tx_valid (pc_tx_valid),
        .pc_tx_ready (pc_tx_ready),
        .pc_rx_data  (pc_rx_data),
        .pc_rx_valid (pc_rx_valid),
        .pc_rx_ready (pc_rx_ready),
        .err         (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle();
        rd_n = 1'b1; wr_n = 1'b1; oe_n = 1'b1;
        pc_tx_valid = 1'b0; pc_rx_ready = 1'b0;
    endtask

    // One clock edge: advance the reference, then compare every output 1 ns later.
    task automatic tick();
        bit         rd_ev, wr_ev, pc_pop, pc_push;
        logic [7:0] wbyte;
        @(posedge clk);
        if (reset) begin
            rx_exp_q.delete();
            tx_exp_q.delete();
            rxf_m = 1'b1;
            txe_m = 1'b1;
            err_m = '0;
        end else begin
            if (!rd_n && oe_prev_m) err_m[0] = 1'b1;
            if (!rd_n && !wr_n)     err_m[1] = 1'b1;
            if (!wr_n && !oe_n)     err_m[2] = 1'b1;
            rd_ev   = !rd_n && !rxf_m;
            wr_ev   = !wr_n && !txe_m;
            pc_pop  = (tx_exp_q.size() > 0) && pc_rx_ready;
            pc_push = pc_tx_valid && (rx_exp_q.size() < DEPTH);
            wbyte   = oe_n ? drv_val : ((rx_exp_q.size() > 0) ? rx_exp_q[0] : 8'h00);
            if (rd_ev)   void'(rx_exp_q.pop_front());
            if (pc_pop)  void'(tx_exp_q.pop_front());
            if (wr_ev)   tx_exp_q.push_back(wbyte);
            if (pc_push) rx_exp_q.push_back(pc_tx_data);
            rxf_m = (rx_exp_q.size() == 0);
            txe_m = (tx_exp_q.size() == DEPTH);
        end
        oe_prev_m = oe_n;
        #1;
        check_eq("rxf", rxf_n, rxf_m);
        check_eq("txe", txe_n, txe_m);
        check_eq("pc_tx_ready", pc_tx_ready, !reset && (rx_exp_q.size() < DEPTH));
        check_eq("pc_rx_valid", pc_rx_valid, !reset && (tx_exp_q.size() > 0));
        if (!reset && tx_exp_q.size() > 0) check_eq("pc_rx_data", pc_rx_data, tx_exp_q[0]);
        check_eq("err", err, err_m);
        if (!oe_n && rx_exp_q.size() > 0) check_eq("bus_rd", data, rx_exp_q[0]);
        else if (oe_n) check_eq("bus_wr", data, drv_val);
    endtask

    initial begin
        logic [7:0] rd_bytes [3];
        rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h22; rd_bytes[2] = 8'h33;
        idle();
        reset = 1'b1; drv_val = 8'h00; pc_tx_data = 8'h00;
        oe_prev_m = 1'b1; rxf_m = 1'b1; txe_m = 1'b1; err_m = '0;

        // Reset and release.
        tick(); tick();
        check_eq("reset_rxf", rxf_n, 1'b1);
        check_eq("reset_txe", txe_n, 1'b1);
        check_eq("reset_tx_ready", pc_tx_ready, 1'b0);
        reset = 1'b0;
        #1 check_eq("post_reset_tx_ready", pc_tx_ready, 1'b1);
        tick();
        check_eq("txe_low_after_reset", txe_n, 1'b0);

        // Read stream of three bytes.
        pc_tx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc_tx_data = rd_bytes[i];
            tick();
        end
        pc_tx_valid = 1'b0;
        oe_n = 1'b0;
        tick();
        rd_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("rd_stream", data, rd_bytes[i]);
            tick();
        end
        rd_n = 1'b1;
        check_eq("rxf_after_last", rxf_n, 1'b1);
        check_eq("rd_stream_err", err, 3'b000);
        oe_n = 1'b1;
        tick();

        // Write fill: 17 strobes, the last one dropped.
        wr_n = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drv_val = 8'(i);
            tick();
            if (i == 15) check_eq("txe_full", txe_n, 1'b1);
        end
        wr_n = 1'b1;
        pc_rx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_eq("drain", pc_rx_data, 8'(i));
            tick();
        end
        pc_rx_ready = 1'b0;
        check_eq("drained", pc_rx_valid, 1'b0);

        // Full TXQ: a PC pop frees one slot that the held write then fills.
        wr_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drv_val = 8'hA0 + 8'(i);
            tick();
        end
        drv_val = 8'hB0;
        pc_rx_ready = 1'b1;
        tick();
        pc_rx_ready = 1'b0;
        tick();
        wr_n = 1'b1;
        check_eq("concur_full", txe_n, 1'b1);
        pc_rx_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            check_eq("concur_drain", pc_rx_data, 8'hA1 + 8'(i));
            tick();
        end
        check_eq("concur_last", pc_rx_data, 8'hB0);
        tick();
        pc_rx_ready = 1'b0;

        // Protocol errors.
        rd_n = 1'b0; tick();
        rd_n = 1'b1; tick();
        check_eq("err_rd_no_oe", err[0], 1'b1);
        tick();
        check_eq("err_sticky", err[0], 1'b1);
        check_eq("err_rd_wr_clear", err[1], 1'b0);
        rd_n = 1'b0; wr_n = 1'b0; drv_val = 8'h5A; tick();
        idle(); tick();
        check_eq("err_rd_wr", err[1], 1'b1);

        // Reset mid-stream.
        pc_tx_valid = 1'b1; pc_tx_data = 8'h77; wr_n = 1'b0; drv_val = 8'h66;
        tick(); tick();
        reset = 1'b1; rd_n = 1'b0;
        tick();
        check_eq("midrst_rxf", rxf_n, 1'b1);
        check_eq("midrst_rx_valid", pc_rx_valid, 1'b0);
        check_eq("midrst_err", err, 3'b000);
        idle();
        reset = 1'b0;
        tick(); tick();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom_range(0, 199) == 0);
            oe_n        = 1'($urandom_range(0, 1));
            rd_n        = 1'($urandom_range(0, 1));
            wr_n        = (!oe_n && rx_exp_q.size() == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            drv_val     = 8'($urandom);
            pc_tx_data  = 8'($urandom);
            pc_tx_valid = 1'($urandom_range(0, 1));
            pc_rx_ready = ($urandom_range(0, 3) == 0);
            tick();
        end

        idle();
        reset = 1'b0;
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
